reglk_ctrl: RTL and testbench

//   Produces the per-register lock vector (reglk_ctrl_o) consumed by the protected

---
 rtl/reglk_pkg.sv | 20 ++
 rtl/reglk_unlock_seq.sv | 103 ++++++++++
 rtl/reglk_ctrl.sv | 91 +++++++++
 tb/tb_reglk_ctrl.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/reglk_pkg.sv
// Shared definitions for the register-lock controller.
//   reglk_state_e : unlock sequencer state, encoding visible on state_o
//   IDX_*         : register-bus word indices decoded by the controller
//   DEF_KEY*      : default unlock keys
package reglk_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        KEY1_WAIT = 2'd1,
        ARMED     = 2'd2,
        LOCKDOWN  = 2'd3
    } reglk_state_e;

    localparam logic [5:0]  IDX_LOCK_SET = 6'd5;
    localparam logic [5:0]  IDX_UNLOCK   = 6'd6;

    localparam logic [31:0] DEF_KEY0 = 32'hA5A5_0F0F;
    localparam logic [31:0] DEF_KEY1 = 32'h5A5A_F0F0;

endpackage

// File: rtl/reglk_unlock_seq.sv
// Two-key unlock sequencer with step timeout and failed-attempt lockdown.
//   clk_i, rst_i  : clock, synchronous active-high reset
//   unlock_wr_i   : bus write to the UNLOCK index this cycle
//   wdata_i       : bus write data (compared against the keys)
//   state_o       : current sequencer state
//   release_o     : combinational strobe, mask write accepted on this edge
//   lockdown_o    : combinational strobe, lockdown entered on this edge
module reglk_unlock_seq
    import reglk_pkg::*;
#(
    parameter logic [31:0] KEY0     = DEF_KEY0,
    parameter logic [31:0] KEY1     = DEF_KEY1,
    parameter int          TIMEOUT  = 16,
    parameter int          MAX_FAIL = 3
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        unlock_wr_i,
    input  logic [31:0] wdata_i,
    output logic [1:0]  state_o,
    output logic        release_o,
    output logic        lockdown_o
);

    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int FW = $clog2(MAX_FAIL + 1);

    reglk_state_e   state_q;
    logic [TW-1:0]  timer_q;
    logic [FW-1:0]  fail_q;
    logic [FW-1:0]  fail_d;
    logic           timer_expired;
    logic           fail_event;

    always_comb begin
        // An UNLOCK write in the timer==0 cycle wins over expiry.
        timer_expired = !unlock_wr_i && (state_q == KEY1_WAIT || state_q == ARMED)
                        && (timer_q == '0);
        fail_event    = timer_expired
                     || (unlock_wr_i && state_q == IDLE      && wdata_i != KEY0)
                     || (unlock_wr_i && state_q == KEY1_WAIT && wdata_i != KEY1);
        fail_d        = (fail_q == FW'(MAX_FAIL)) ? fail_q : fail_q + 1'b1;
        lockdown_o    = fail_event && (fail_d == FW'(MAX_FAIL));
        release_o     = unlock_wr_i && (state_q == ARMED);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            timer_q <= '0;
            fail_q  <= '0;
        end else begin
            if (fail_event) begin
                fail_q <= fail_d;
            end else if (release_o) begin
                fail_q <= '0;
            end

            if (lockdown_o) begin
                state_q <= LOCKDOWN;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (unlock_wr_i && wdata_i == KEY0) begin
                            state_q <= KEY1_WAIT;
                            timer_q <= TW'(TIMEOUT - 1);
                        end
                    end
                    KEY1_WAIT: begin
                        if (unlock_wr_i) begin
                            if (wdata_i == KEY1) begin
                                state_q <= ARMED;
                                timer_q <= TW'(TIMEOUT - 1);
                            end else begin
                                state_q <= IDLE;
                            end
                        end else if (timer_q == '0) begin
                            state_q <= IDLE;
                        end else begin
                            timer_q <= timer_q - 1'b1;
                        end
                    end
                    ARMED: begin
                        if (unlock_wr_i) begin
                            state_q <= IDLE;
                        end else if (timer_q == '0) begin
                            state_q <= IDLE;
                        end else begin
                            timer_q <= timer_q - 1'b1;
                        end
                    end
                    LOCKDOWN: begin
                        // Held until reset.
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign state_o = state_q;

endmodule

// File: rtl/reglk_ctrl.sv
// Register lock controller: sticky per-register lock bits, released only via
// the two-key unlock sequence, with a one-cycle scrub pulse per released bit.
//   clk_i, rst_i   : clock, synchronous active-high reset
//   en, we         : bus access / write enable
//   address        : bus address, word index = address[8:3]
//   wdata          : bus write data
//   reglk_ctrl_o   : lock vector, bit i=1 freezes register i
//   scrub_o        : one-cycle pulse, clear register i
//   state_o        : unlock sequencer state
//   locked_down_o  : sticky lockdown flag
module reglk_ctrl
    import reglk_pkg::*;
#(
    parameter int                   NUM_REGS   = 4,
    parameter int                   ADDR_W     = 9,
    parameter logic [31:0]          KEY0       = DEF_KEY0,
    parameter logic [31:0]          KEY1       = DEF_KEY1,
    parameter int                   TIMEOUT    = 16,
    parameter int                   MAX_FAIL   = 3,
    parameter logic [NUM_REGS-1:0]  RESET_LOCK = '0
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 en,
    input  logic                 we,
    input  logic [ADDR_W-1:0]    address,
    input  logic [31:0]          wdata,
    output logic [NUM_REGS-1:0]  reglk_ctrl_o,
    output logic [NUM_REGS-1:0]  scrub_o,
    output logic [1:0]           state_o,
    output logic                 locked_down_o
);

    logic [5:0]           idx;
    logic                 wr;
    logic                 lock_set_wr;
    logic                 unlock_wr;
    logic                 release_s;
    logic                 lockdown_s;
    logic                 unused_addr;
    logic [NUM_REGS-1:0]  reglk_q, reglk_d;
    logic [NUM_REGS-1:0]  scrub_q, scrub_d;
    logic                 locked_down_q;

    assign wr          = en & we;
    assign idx         = address[8:3];
    assign unused_addr = ^address[2:0];
    assign lock_set_wr = wr && (idx == IDX_LOCK_SET);
    assign unlock_wr   = wr && (idx == IDX_UNLOCK);

    reglk_unlock_seq #(
        .KEY0     (KEY0),
        .KEY1     (KEY1),
        .TIMEOUT  (TIMEOUT),
        .MAX_FAIL (MAX_FAIL)
    ) u_seq (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .unlock_wr_i (unlock_wr),
        .wdata_i     (wdata),
        .state_o     (state_o),
        .release_o   (release_s),
        .lockdown_o  (lockdown_s)
    );

    // Only bits that are currently locked can be released and scrubbed.
    // Lockdown forces every bit on, over any merge in the same cycle.
    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_bit
        assign scrub_d[gi] = release_s & wdata[gi] & reglk_q[gi];
        assign reglk_d[gi] = lockdown_s  ? 1'b1 :
                             scrub_d[gi] ? 1'b0 :
                             (reglk_q[gi] | (lock_set_wr & wdata[gi]));
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            reglk_q       <= RESET_LOCK;
            scrub_q       <= '0;
            locked_down_q <= 1'b0;
        end else begin
            reglk_q       <= reglk_d;
            scrub_q       <= scrub_d;
            locked_down_q <= locked_down_q | lockdown_s;
        end
    end

    assign reglk_ctrl_o  = reglk_q;
    assign scrub_o       = scrub_q;
    assign locked_down_o = locked_down_q;

endmodule

// File: tb/tb_reglk_ctrl.sv
module tb_reglk_ctrl;

    localparam logic [31:0] K0 = 32'hA5A5_0F0F;
    localparam logic [31:0] K1 = 32'h5A5A_F0F0;
    localparam int          TO = 16;
    localparam int          MAXF = 3;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic        en = 1'b0;
    logic        we = 1'b0;
    logic [8:0]  address = '0;
    logic [31:0] wdata = '0;
    logic [3:0]  reglk_ctrl_o;
    logic [3:0]  scrub_o;
    logic [1:0]  state_o;
    logic        locked_down_o;

    always #5 clk = ~clk;

    reglk_ctrl dut (
        .clk_i         (clk),
        .rst_i         (rst_i),
        .en            (en),
        .we            (we),
        .address       (address),
        .wdata         (wdata),
        .reglk_ctrl_o  (reglk_ctrl_o),
        .scrub_o       (scrub_o),
        .state_o       (state_o),
        .locked_down_o (locked_down_o)
    );

    typedef struct packed {
        logic [3:0] lock;
        logic [3:0] scrub;
        logic [1:0] state;
        logic       dead;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;
    bit   stim_done = 0;

    // Reference model: which key step has been reached, the cycle it was
    // reached, and how many failures have accumulated.
    logic [3:0] m_lock;
    logic [3:0] m_scrub;
    int         m_step;      // 0 none, 1 KEY0 seen, 2 both keys seen
    int         m_step_cyc;
    int         m_fails;
    bit         m_dead;
    int         cyc = 0;

    function automatic logic [8:0] addr_of(input int ix);
        logic [5:0] i6;
        logic [2:0] lo;
        i6 = 6'(ix);
        lo = 3'($urandom_range(0, 7));
        return {i6, lo};
    endfunction

    task automatic model_edge(input logic r, input logic e, input logic w,
                              input logic [8:0] a, input logic [31:0] d);
        bit fail;
        bit lset;
        bit unl;
        logic [3:0] m;
        cyc++;
        fail = 0;
        if (r) begin
            m_lock = 4'b0000; m_scrub = 4'b0000; m_step = 0; m_fails = 0; m_dead = 0;
            return;
        end
        m_scrub = 4'b0000;
        lset = e && w && (a[8:3] == 6'd5);
        unl  = e && w && (a[8:3] == 6'd6);
        if (lset) m_lock = m_lock | d[3:0];
        if (!m_dead) begin
            if (unl) begin
                if (m_step == 0) begin
                    if (d == K0) begin m_step = 1; m_step_cyc = cyc; end
                    else fail = 1;
                end else if (m_step == 1) begin
                    if (d == K1) begin m_step = 2; m_step_cyc = cyc; end
                    else begin fail = 1; m_step = 0; end
                end else begin
                    m = d[3:0] & m_lock;
                    m_lock  = m_lock & ~m;
                    m_scrub = m;
                    m_step  = 0;
                    m_fails = 0;
                end
            end else if (m_step != 0 && cyc == m_step_cyc + TO) begin
                fail = 1;
                m_step = 0;
            end
            if (fail) begin
                if (m_fails < MAXF) m_fails++;
                if (m_fails == MAXF) begin
                    m_dead = 1;
                    m_lock = 4'hF;
                end
            end
        end
    endtask

    task automatic drive(input logic r, input logic e, input logic w,
                         input logic [8:0] a, input logic [31:0] d);
        exp_t x;
        @(negedge clk);
        rst_i = r; en = e; we = w; address = a; wdata = d;
        model_edge(r, e, w, a, d);
        x.lock  = m_lock;
        x.scrub = m_scrub;
        x.state = m_dead ? 2'd3 : 2'(m_step);
        x.dead  = m_dead;
        exp_q.push_back(x);
        if (r || e)
            $display("txn cyc=%0d rst=%0b en=%0b we=%0b idx=%0d wdata=%h exp lock=%b scrub=%b state=%0d dead=%0b",
                     cyc, r, e, w, a[8:3], d, x.lock, x.scrub, x.state, x.dead);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 0, 0, '0, '0);
    endtask

    task automatic wr_idx(input int ix, input logic [31:0] d);
        drive(0, 1, 1, addr_of(ix), d);
    endtask

    // Random filler cycle: nothing, reads, stray writes or lock-sets.
    task automatic filler();
        int k;
        k = $urandom_range(0, 5);
        case (k)
            0, 1: idle(1);
            2: drive(0, 1, 0, addr_of(6), ($urandom_range(0, 1) != 0) ? K1 : K0);
            3: wr_idx(($urandom_range(0, 1) != 0) ? 4 : 7, $urandom);
            4: wr_idx(5, 32'($urandom_range(0, 15)) & 32'h5);
            default: drive(0, 0, 1, addr_of(6), K0);
        endcase
    endtask

    task automatic gap();
        int g;
        if ($urandom_range(0, 3) == 0) g = $urandom_range(14, 17);
        else g = $urandom_range(0, 3);
        for (int i = 0; i < g; i++) filler();
    endtask

    task automatic check(input string name, input int act, input int expv);
        total++;
        if (act != expv) begin
            bad++;
            $display("FAIL %s at t=%0t: got %0h expected %0h", name, $time, act, expv);
        end
    endtask

    // Monitor: one expected record per clocked cycle, compared after the edge.
    initial begin
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                x = exp_q.pop_front();
                check("reglk_ctrl_o",  int'(reglk_ctrl_o),  int'(x.lock));
                check("scrub_o",       int'(scrub_o),       int'(x.scrub));
                check("state_o",       int'(state_o),       int'(x.state));
                check("locked_down_o", int'(locked_down_o), int'(x.dead));
            end
        end
    end

    initial begin
        m_lock = '0; m_scrub = '0; m_step = 0; m_step_cyc = 0; m_fails = 0; m_dead = 0;

        // 1. reset, LOCK_SET 0101
        drive(1, 0, 0, '0, '0);
        drive(1, 1, 1, addr_of(5), 32'hF);   // reset overrides the write
        wr_idx(5, 32'h5);
        idle(1);
        // 2. full unlock releasing bit 2
        wr_idx(6, K0); wr_idx(6, K1); wr_idx(6, 32'h4);
        idle(2);
        // 3. KEY0 then timeout
        wr_idx(6, K0);
        idle(20);
        // 4. lockdown, ignored unlock, lock-set still honoured, reset
        wr_idx(6, 32'h0); wr_idx(6, 32'h0); wr_idx(6, 32'h0);
        wr_idx(6, K0); wr_idx(6, K1); wr_idx(6, 32'hF);
        wr_idx(5, 32'h3);
        idle(2);
        drive(1, 0, 0, '0, '0);
        idle(1);
        // 5. mask 1010 over reglk 0010
        wr_idx(5, 32'h2);
        wr_idx(6, K0); wr_idx(6, K1); wr_idx(6, 32'hA);
        idle(2);
        // 6. reset on the mask-write cycle
        wr_idx(5, 32'h3);
        wr_idx(6, K0); wr_idx(6, K1);
        drive(1, 1, 1, addr_of(6), 32'hF);
        idle(2);
        // boundary: mask write exactly in the timer==0 cycle, and one late
        wr_idx(5, 32'hF);
        wr_idx(6, K0); idle(TO - 1); wr_idx(6, K1); idle(TO - 1); wr_idx(6, 32'h1);
        wr_idx(6, K0); idle(TO);     wr_idx(6, K1);
        drive(1, 0, 0, '0, '0);

        // Randomized unlock attempts
        for (int n = 0; n < 70; n++) begin
            if ($urandom_range(0, 7) == 0 || (m_dead && $urandom_range(0, 1) == 0))
                drive(1, 0, 0, '0, '0);
            wr_idx(5, 32'($urandom_range(0, 15)));
            gap();
            wr_idx(6, ($urandom_range(0, 7) == 0) ? $urandom : K0);
            gap();
            wr_idx(6, ($urandom_range(0, 7) == 0) ? $urandom : K1);
            gap();
            wr_idx(6, $urandom);
            gap();
        end
        idle(2);
        stim_done = 1;
    end

    initial begin
        int waited;
        wait (stim_done);
        waited = 0;
        while (exp_q.size() > 0 && waited < 10) begin
            @(posedge clk);
            waited++;
        end
        #2;
        if (exp_q.size() > 0) begin
            total++;
            bad++;
            $display("FAIL drain: %0d expected records left, required 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
